// File: rtl/wb_pkg.sv
// wb_pkg
//   Shared definitions for the Wishbone master controller: the command
//   op encoding, the controller state enum and small decode helpers.
//   Imported by wb_master_ctrl and wb_ack_timer.
package wb_pkg;

  // Command op encoding as presented on cmd_op_i.
  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_RMW     = 2'd2,
    OP_ILLEGAL = 2'd3
  } wb_op_e;

  // Controller states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_GAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_RSP  = 3'd4
  } wb_state_e;

  // Ops whose first bus phase is a read strobe.
  function automatic logic op_starts_with_read(input wb_op_e op);
    return (op == OP_READ) || (op == OP_RMW);
  endfunction

  // Width of a counter able to hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage : wb_pkg

// File: rtl/wb_ack_timer.sv
// wb_ack_timer
//   Per-phase acknowledge timeout counter. It counts clock edges on which
//   the strobe is asserted; the count is held at zero whenever the strobe
//   is low, so it restarts automatically on entry to every strobe phase.
//   expired is high on the TIMEOUT-th strobe cycle of a phase, so the
//   controller sees exactly TIMEOUT strobe cycles before giving up.
// Ports
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-low reset
//   run     : strobe currently asserted (phase in progress)
//   expired : last allowed strobe cycle of the phase, no ack yet
module wb_ack_timer
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  assign expired = run && (count == LAST);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count <= '0;
    end else if (!run) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + 1'b1;
    end
  end

endmodule : wb_ack_timer

// File: rtl/wb_master_ctrl.sv
// wb_master_ctrl
//   Single-outstanding Wishbone classic master. Accepts one command
//   (read, write, read-modify-write or illegal) through a valid/ready
//   handshake, runs the bus phases and returns one response through a
//   valid/ready handshake. All bus outputs are registered.
//   A read-modify-write keeps cyc_o asserted across both phases with one
//   idle cycle (stb_o low) between the read and the write strobe.
// Ports
//   clk_i, rst_i                    : clock, async active-low reset
//   cmd_valid_i/cmd_ready_o         : command handshake
//   cmd_op_i/adr/sel/dat            : command fields, captured on accept
//   rsp_valid_o/rsp_ready_i         : response handshake
//   rsp_dat_o/rsp_err_o             : read data, timeout/illegal flag
//   adr_o/dat_o/dat_i/sel_o/we_o    : Wishbone address/data/select/write
//   cyc_o/stb_o/ack_i               : Wishbone cycle/strobe/acknowledge
module wb_master_ctrl
  import wb_pkg::*;
#(
  parameter  int ADDR_WIDTH  = 16,
  parameter  int DATA_WIDTH  = 32,
  parameter  int GRANULE     = 8,
  parameter  int ACK_TIMEOUT = 16,
  localparam int SEL_WIDTH   = DATA_WIDTH / GRANULE
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // command side
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [SEL_WIDTH-1:0]  cmd_sel_i,
  input  logic [DATA_WIDTH-1:0] cmd_dat_i,
  // response side
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_dat_o,
  output logic                  rsp_err_o,
  // Wishbone master
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [SEL_WIDTH-1:0]  sel_o,
  output logic                  we_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  input  logic                  ack_i
);

  wb_state_e             state;
  wb_op_e                op_reg;
  logic [DATA_WIDTH-1:0] dat_reg;
  logic                  timed_out;
  logic                  bus_ack;
  wb_op_e                cmd_op;

  assign cmd_op  = wb_op_e'(cmd_op_i);
  // An ack outside a strobe phase carries no meaning and is dropped here.
  assign bus_ack = ack_i && stb_o;

  wb_ack_timer #(
    .TIMEOUT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .run     (stb_o),
    .expired (timed_out)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= ST_IDLE;
      op_reg      <= OP_READ;
      dat_reg     <= '0;
      cmd_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
      adr_o       <= '0;
      dat_o       <= '0;
      sel_o       <= '0;
      we_o        <= 1'b0;
      cyc_o       <= 1'b0;
      stb_o       <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            op_reg      <= cmd_op;
            adr_o       <= cmd_adr_i;
            sel_o       <= cmd_sel_i;
            dat_reg     <= cmd_dat_i;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b0;
            cmd_ready_o <= 1'b0;
            if (op_starts_with_read(cmd_op)) begin
              state <= ST_RD;
              cyc_o <= 1'b1;
              stb_o <= 1'b1;
              we_o  <= 1'b0;
            end else if (cmd_op == OP_WRITE) begin
              state <= ST_WR;
              cyc_o <= 1'b1;
              stb_o <= 1'b1;
              we_o  <= 1'b1;
              dat_o <= cmd_dat_i;
            end else begin
              // Illegal op: answer straight away, never touch the bus.
              state       <= ST_RSP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
            end
          end else begin
            // Also raises ready on the first edge after reset release.
            cmd_ready_o <= 1'b1;
          end
        end

        ST_RD: begin
          if (bus_ack) begin
            rsp_dat_o <= dat_i;
            stb_o     <= 1'b0;
            if (op_reg == OP_RMW) begin
              // Keep cyc_o so the bus stays locked for the write phase.
              state <= ST_GAP;
            end else begin
              state       <= ST_RSP;
              cyc_o       <= 1'b0;
              rsp_valid_o <= 1'b1;
            end
          end else if (timed_out) begin
            // Abandon the whole command, including any pending write phase.
            state       <= ST_RSP;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
          end
        end

        ST_GAP: begin
          state <= ST_WR;
          stb_o <= 1'b1;
          we_o  <= 1'b1;
          dat_o <= dat_reg;
        end

        ST_WR: begin
          if (bus_ack || timed_out) begin
            state       <= ST_RSP;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            we_o        <= 1'b0;
            dat_o       <= '0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= !bus_ack;
          end
        end

        ST_RSP: begin
          if (rsp_ready_i) begin
            state       <= ST_IDLE;
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
          end
        end

        default: begin
          state       <= ST_IDLE;
          cyc_o       <= 1'b0;
          stb_o       <= 1'b0;
          we_o        <= 1'b0;
          rsp_valid_o <= 1'b0;
          cmd_ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule : wb_master_ctrl

// File: tb/tb_wb_master_ctrl.sv
// tb_wb_master_ctrl
//   Directed bench for wb_master_ctrl with a small word-addressed Wishbone
//   slave (16 words, byte lanes, ack on a configurable strobe cycle).
module tb_wb_master_ctrl;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_adr;
  logic [SW-1:0] cmd_sel;
  logic [DW-1:0] cmd_dat;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_dat;
  logic          rsp_err;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o;
  logic [DW-1:0] dat_i;
  logic [SW-1:0] sel_o;
  logic          we_o;
  logic          cyc_o;
  logic          stb_o;
  logic          ack_i;

  always #5 clk = ~clk;

  wb_master_ctrl #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .GRANULE     (8),
    .ACK_TIMEOUT (16)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_adr_i   (cmd_adr),
    .cmd_sel_i   (cmd_sel),
    .cmd_dat_i   (cmd_dat),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_err_o   (rsp_err),
    .adr_o       (adr_o),
    .dat_o       (dat_o),
    .dat_i       (dat_i),
    .sel_o       (sel_o),
    .we_o        (we_o),
    .cyc_o       (cyc_o),
    .stb_o       (stb_o),
    .ack_i       (ack_i)
  );

  // ---------------- slave model ----------------
  logic [DW-1:0] mem [0:15];
  logic          ack_en    = 1'b1;
  logic          stray_ack = 1'b0;
  int            ack_lat   = 2;
  int            scnt      = 0;

  always @(negedge clk) begin
    if (stb_o) begin
      scnt  = scnt + 1;
      ack_i = stray_ack || (ack_en && (scnt == ack_lat));
      dat_i = mem[adr_o[5:2]];
    end else begin
      scnt  = 0;
      ack_i = stray_ack;
      dat_i = 32'hBAD0_BAD0;
    end
  end

  always @(posedge clk) begin
    if (rst_i && ack_i && stb_o && we_o) begin
      for (int l = 0; l < SW; l++) begin
        if (sel_o[l]) mem[adr_o[5:2]][8*l +: 8] <= dat_o[8*l +: 8];
      end
    end
  end

  // ---------------- bus monitor ----------------
  int            mon_stb, mon_gap, mon_we, mon_cyc;
  logic [DW-1:0] mon_wdat;
  logic [SW-1:0] mon_wsel;
  logic [AW-1:0] mon_adr;

  always @(negedge clk) begin
    if (stb_o) begin
      mon_stb = mon_stb + 1;
      mon_adr = adr_o;
    end
    if (cyc_o && !stb_o) mon_gap = mon_gap + 1;
    if (cyc_o) mon_cyc = mon_cyc + 1;
    if (stb_o && we_o) begin
      mon_we   = mon_we + 1;
      mon_wdat = dat_o;
      mon_wsel = sel_o;
    end
  end

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    mon_stb  = 0;
    mon_gap  = 0;
    mon_we   = 0;
    mon_cyc  = 0;
    mon_wdat = '0;
    mon_wsel = '0;
    mon_adr  = '0;
  endtask

  logic lat_cyc;

  task automatic send(input logic [1:0] op, input logic [AW-1:0] adr,
                      input logic [SW-1:0] sel, input logic [DW-1:0] dat);
    int n;
    clear_mon();
    @(negedge clk);
    cmd_op    = op;
    cmd_adr   = adr;
    cmd_sel   = sel;
    cmd_dat   = dat;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_seen", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_adr   = AW'($urandom);
    cmd_sel   = SW'($urandom);
    cmd_dat   = $urandom;
    lat_cyc   = cyc_o;
  endtask

  task automatic get_rsp(input int hold, output logic [DW-1:0] d, output logic e);
    int   n;
    logic stable;
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rsp_valid_seen", 64'(rsp_valid), 64'd1);
    d = rsp_dat;
    e = rsp_err;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_dat !== d || rsp_err !== e) stable = 1'b0;
    end
    if (hold > 0) check("rsp_stable", 64'(stable), 64'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_drop", 64'(rsp_valid), 64'd0);
    $display("txn: adr=0x%04h rsp_dat=0x%08h rsp_err=%0d stb_cycles=%0d gap=%0d",
             mon_adr, d, e, mon_stb, mon_gap);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, 64'({cyc_o, stb_o, we_o, rsp_valid, rsp_err, cmd_ready, sel_o, adr_o}), 64'd0);
    check({tag, "_data"}, {dat_o, rsp_dat}, 64'd0);
  endtask

  logic [DW-1:0] d;
  logic          e;

  initial begin
    rst_i     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_adr   = '0;
    cmd_sel   = '0;
    cmd_dat   = '0;
    rsp_ready = 1'b0;
    ack_i     = 1'b0;
    dat_i     = '0;
    clear_mon();
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[1] = 32'hDEAD_BEEF;

    // reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_i = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(cmd_ready), 64'd1);

    // read, ack on 2nd strobe cycle
    send(2'd0, 16'h0004, 4'hF, 32'h0);
    check("rd_latency_cyc", 64'(lat_cyc), 64'd1);
    get_rsp(0, d, e);
    check("rd_data", 64'(d), 64'hDEAD_BEEF);
    check("rd_err", 64'(e), 64'd0);
    check("rd_stb_cycles", 64'(mon_stb), 64'd2);
    check("rd_we_cycles", 64'(mon_we), 64'd0);
    check("rd_adr", 64'(mon_adr), 64'h0004);
    check("rd_cyc_after", 64'(cyc_o), 64'd0);

    // write with partial select
    send(2'd1, 16'h0008, 4'h3, 32'h1234_5678);
    get_rsp(0, d, e);
    check("wr_dat_o", 64'(mon_wdat), 64'h1234_5678);
    check("wr_sel_o", 64'(mon_wsel), 64'h3);
    check("wr_we_cycles", 64'(mon_we), 64'd2);
    check("wr_rsp_dat", 64'(d), 64'd0);
    check("wr_err", 64'(e), 64'd0);
    check("wr_mem", 64'(mem[2]), 64'h0000_5678);

    // read back the partially written word
    send(2'd0, 16'h0008, 4'hF, 32'h0);
    get_rsp(0, d, e);
    check("rdback_data", 64'(d), 64'h0000_5678);

    // read-modify-write
    mem[1] = 32'hA5A5_A5A5;
    send(2'd2, 16'h0004, 4'hF, 32'h0F0F_0F0F);
    get_rsp(0, d, e);
    check("rmw_rsp_dat", 64'(d), 64'hA5A5_A5A5);
    check("rmw_err", 64'(e), 64'd0);
    check("rmw_gap_cycles", 64'(mon_gap), 64'd1);
    check("rmw_stb_cycles", 64'(mon_stb), 64'd4);
    check("rmw_mem", 64'(mem[1]), 64'h0F0F_0F0F);

    // read with no ack -> timeout after 16 strobe cycles
    ack_en = 1'b0;
    send(2'd0, 16'h000C, 4'hF, 32'h0);
    get_rsp(0, d, e);
    check("to_err", 64'(e), 64'd1);
    check("to_rsp_dat", 64'(d), 64'd0);
    check("to_stb_cycles", 64'(mon_stb), 64'd16);
    check("to_cyc_after", 64'(cyc_o), 64'd0);
    ack_en = 1'b1;

    // illegal op, response held for 5 cycles
    send(2'd3, 16'h0010, 4'hF, 32'h0);
    check("ill_latency_cyc", 64'(lat_cyc), 64'd0);
    get_rsp(5, d, e);
    check("ill_err", 64'(e), 64'd1);
    check("ill_rsp_dat", 64'(d), 64'd0);
    check("ill_cyc_cycles", 64'(mon_cyc), 64'd0);

    // stray ack while idle must do nothing
    stray_ack = 1'b1;
    repeat (4) @(negedge clk);
    check("stray_idle", 64'({cyc_o, rsp_valid, cmd_ready}), 64'b001);
    stray_ack = 1'b0;
    @(negedge clk);

    // reset during RMW gap
    send(2'd2, 16'h0004, 4'hF, 32'h1111_1111);
    begin
      int n;
      n = 0;
      while (!(cyc_o && !stb_o) && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("gap_reached", 64'({cyc_o, stb_o}), 64'b10);
    rst_i = 1'b0;
    #1;
    check_all_zero("midrst");
    check("midrst_mem", 64'(mem[1]), 64'h0F0F_0F0F);
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_no_rsp", 64'({rsp_valid, cyc_o}), 64'd0);
    send(2'd0, 16'h0004, 4'hF, 32'h0);
    get_rsp(0, d, e);
    check("post_rst_rd_data", 64'(d), 64'h0F0F_0F0F);
    check("post_rst_rd_err", 64'(e), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_wb_master_ctrl
